put_motion_code: RTL

//  MPEG-2 motion_code VLC encoder and bit packer (Table B-10), the transmit-side counterpart of the motion code decoder.

---
 rtl/mpeg_vlc_pkg.sv | 32 +++
 rtl/mv_vlc_lut.sv | 28 ++
 rtl/put_motion_code.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mpeg_vlc_pkg.sv
// Shared constants for the MPEG-2 motion_code VLC (Table B-10).
// Codewords are stored per |motion_code| without the trailing sign bit.
package mpeg_vlc_pkg;

  localparam int MV_MAX    = 16;
  localparam int MV_CODE_W = 11;  // longest codeword including sign bit

  // Codeword value (right-aligned) and length for |m| = 0..16, sign bit excluded
  localparam logic [9:0] MV_VLC_CODE [0:MV_MAX] = '{
    10'd1,  10'd1,  10'd1,  10'd1,  10'd3,  10'd5,  10'd4,  10'd3,
    10'd11, 10'd10, 10'd9,  10'd17, 10'd16, 10'd15, 10'd14, 10'd13,
    10'd12
  };
  localparam logic [3:0] MV_VLC_LEN [0:MV_MAX] = '{
    4'd1,  4'd2,  4'd3,  4'd4,  4'd6,  4'd7,  4'd7,  4'd7,
    4'd9,  4'd9,  4'd9,  4'd10, 4'd10, 4'd10, 4'd10, 4'd10,
    4'd10
  };

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } mv_state_e;

  // LUT result: full codeword (sign included), its length, illegal flag
  typedef struct packed {
    logic [MV_CODE_W-1:0] code;
    logic [3:0]           len;
    logic                 illegal;
  } mv_vlc_t;

endpackage

// File: rtl/mv_vlc_lut.sv
// Combinational motion_code -> VLC codeword lookup.
// Codeword is right-aligned; for m!=0 the sign bit (1 = negative) is the LSB.
module mv_vlc_lut
  import mpeg_vlc_pkg::*;
(
  input  logic signed [5:0] mcode,
  output mv_vlc_t           vlc
);

  logic [5:0] mag;

  // Magnitude, range check and table lookup
  always_comb begin
    mag = mcode[5] ? (~mcode + 6'd1) : mcode;
    vlc = '0;
    vlc.illegal = (mag > 6'd16);
    if (!vlc.illegal) begin
      if (mag == 6'd0) begin
        vlc.code = 11'd1;
        vlc.len  = 4'd1;
      end else begin
        vlc.code = {MV_VLC_CODE[mag[4:0]], mcode[5]};
        vlc.len  = MV_VLC_LEN[mag[4:0]] + 4'd1;
      end
    end
  end

endmodule

// File: rtl/put_motion_code.sv
// MPEG-2 motion_code VLC encoder and MSB-first bit packer.
// Optional build macro MOTION_RESIDUAL_EN: append motion_residual bits after
// the sign bit. Without it r_size/residual are present but ignored.
module put_motion_code
  import mpeg_vlc_pkg::*;
#(
  parameter int WORD_W    = 16,
  parameter int RSIZE_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [5:0]    mcode,
  input  logic [3:0]           r_size,
  input  logic [RSIZE_MAX-1:0] residual,
  input  logic                 flush,
  output logic                 flush_done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_W-1:0]    out_data,
  output logic                 err
);

  localparam int ACC_W  = WORD_W + MV_CODE_W + RSIZE_MAX;
  localparam int SYM_W  = MV_CODE_W + RSIZE_MAX;
  localparam int FILL_W = $clog2(ACC_W + 1);

  // Accumulator bits are left-aligned; everything below fill is kept zero so
  // the top word is already zero-padded when a partial word is flushed.
  logic [ACC_W-1:0]  acc;
  logic [FILL_W-1:0] fill;
  mv_state_e         state;
  logic              err_q;

  mv_vlc_t           vlc;
  logic [SYM_W-1:0]  sym;
  logic [FILL_W-1:0] sym_len;
  logic              drop;
  logic [ACC_W-1:0]  sym_left;
  logic [ACC_W-1:0]  app;
  logic              accept;
  logic              emit;

  mv_vlc_lut u_lut (
    .mcode (mcode),
    .vlc   (vlc)
  );

`ifdef MOTION_RESIDUAL_EN
  // Symbol = codeword followed by r_size residual bits (never for m==0)
  always_comb begin
    sym     = SYM_W'(vlc.code);
    sym_len = FILL_W'(vlc.len);
    drop    = vlc.illegal;
    if (!vlc.illegal && mcode != 6'sd0) begin
      if (int'(r_size) > RSIZE_MAX) begin
        drop = 1'b1;
      end else if (r_size != 4'd0) begin
        sym     = (SYM_W'(vlc.code) << r_size)
                | (SYM_W'(residual) & ~({SYM_W{1'b1}} << r_size));
        sym_len = FILL_W'(vlc.len) + FILL_W'(r_size);
      end
    end
  end
`else
  // Symbol is the bare codeword
  always_comb begin
    sym     = SYM_W'(vlc.code);
    sym_len = FILL_W'(vlc.len);
    drop    = vlc.illegal;
  end

  logic unused_residual;
  assign unused_residual = ^{r_size, residual};
`endif

  // Place the symbol directly below the current fill point
  always_comb begin
    sym_left = ACC_W'(sym) << (FILL_W'(ACC_W) - sym_len);
    app      = sym_left >> fill;
  end

  // Handshakes derive from registers only; accept needs fill<WORD_W in RUN
  // while emit in RUN needs fill>=WORD_W, so the two never coincide.
  assign in_ready   = (state == RUN) && (fill < FILL_W'(WORD_W));
  assign out_valid  = (fill >= FILL_W'(WORD_W)) || ((state == FLUSH) && (fill != '0));
  assign out_data   = acc[ACC_W-1 -: WORD_W];
  assign flush_done = (state == FLUSH) && (fill == '0);
  assign err        = err_q;
  assign accept     = in_valid && in_ready;
  assign emit       = out_valid && out_ready;

  // Accumulator, fill counter, error pulse and RUN/FLUSH control
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      fill  <= '0;
      state <= RUN;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (accept) begin
        if (drop) begin
          err_q <= 1'b1;
        end else begin
          acc  <= acc | app;
          fill <= fill + sym_len;
        end
      end else if (emit) begin
        acc  <= acc << WORD_W;
        fill <= (fill >= FILL_W'(WORD_W)) ? fill - FILL_W'(WORD_W) : '0;
      end

      case (state)
        RUN:     if (flush) state <= FLUSH;
        FLUSH:   if (fill == '0) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule
